// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions for the program-counter unit: default widths,
// controller opcodeFunc encodings and the next-pc action type.
package pc_unit_pkg;

  localparam int PC_W_DEF  = 12;
  localparam int OFF_W_DEF = 8;
  localparam int DEPTH_DEF = 8;

  localparam logic [4:0] OPF_JMP   = 5'b11100;
  localparam logic [4:0] OPF_CALL  = 5'b11101;
  localparam logic [4:0] OPF_RET   = 5'b11110;
  localparam logic [4:0] OPF_BR_LO = 5'b10100;
  localparam logic [4:0] OPF_BR_HI = 5'b10111;

  typedef enum logic [1:0] {
    ACT_SEQ    = 2'd0,
    ACT_BRANCH = 2'd1,
    ACT_JMP    = 2'd2,
    ACT_RET    = 2'd3
  } pc_act_e;

  // Branch opcodes occupy 101xx.
  function automatic logic is_branch_opf(input logic [4:0] opf);
    return opf[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: storage array, stack pointer, full/empty decode and
// sticky overflow/underflow flag.
module ret_stack
  import pc_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic            pop_en,
  input  logic            push_en,
  input  logic [PC_W-1:0] wr_data,
  output logic [PC_W-1:0] rd_data,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [PC_W-1:0]  mem_q [DEPTH];

  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SP_W'(DEPTH));
  assign err    = err_q;
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign rd_data = mem_q[rd_idx];

  // A return has priority over a call; callers gate both with the advance enable.
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (rd_en) begin
      if (empty)       err_d = 1'b1;
      else if (pop_en) sp_d  = sp_q - SP_W'(1);
    end else if (push_en) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately not reset; sp=0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with absolute jump, call/return via ret_stack and
// pc-relative taken branches.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcEn,
  input  logic             jmp,
  input  logic             push,
  input  logic             ret,
  input  logic             pop,
  input  logic             branch,
  input  logic [PC_W-1:0]  jmpAddr,
  input  logic [OFF_W-1:0] branchOff,
  output logic [PC_W-1:0]  pc,
  output logic             stackEmpty,
  output logic             stackFull,
  output logic             stackErr
);

  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        top_data;
  logic signed [PC_W-1:0] off_ext;
  pc_act_e                act;

  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(branchOff));
  assign pc      = pc_q;

  ret_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (pcEn & ret),
    .pop_en  (pcEn & ret & pop),
    .push_en (pcEn & jmp & push),
    .wr_data (pc_inc),
    .rd_data (top_data),
    .empty   (stackEmpty),
    .full    (stackFull),
    .err     (stackErr)
  );

  always_comb begin
    act = ACT_SEQ;
    if (ret)         act = ACT_RET;
    else if (jmp)    act = ACT_JMP;
    else if (branch) act = ACT_BRANCH;

    pc_d = pc_q;
    if (pcEn) begin
      case (act)
        ACT_RET:    pc_d = stackEmpty ? pc_inc : top_data;
        ACT_JMP:    pc_d = jmpAddr;
        ACT_BRANCH: pc_d = pc_inc + off_ext;
        default:    pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: vector table plus a deep call/return sequence.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, pcEn, jmp, push, ret, pop, branch;
  logic [11:0] jmpAddr;
  logic [7:0]  branchOff;
  logic [11:0] pc;
  logic        stackEmpty, stackFull, stackErr;

  typedef struct {
    logic        rst, en, jmp, push, ret, pop, br;
    logic [11:0] jaddr;
    logic [7:0]  boff;
    logic [11:0] epc;
    logic        eempty, efull, eerr;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  pc_unit #(.PC_W(12), .OFF_W(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcEn       (pcEn),
    .jmp        (jmp),
    .push       (push),
    .ret        (ret),
    .pop        (pop),
    .branch     (branch),
    .jmpAddr    (jmpAddr),
    .branchOff  (branchOff),
    .pc         (pc),
    .stackEmpty (stackEmpty),
    .stackFull  (stackFull),
    .stackErr   (stackErr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, en, j, pu, rt, po, b,
                     input logic [11:0] ja, input logic [7:0] bo,
                     input logic [11:0] epc, input logic ee, ef, er);
    vec_t v;
    v.rst = r; v.en = en; v.jmp = j; v.push = pu; v.ret = rt; v.pop = po; v.br = b;
    v.jaddr = ja; v.boff = bo; v.epc = epc; v.eempty = ee; v.efull = ef; v.eerr = er;
    vecs.push_back(v);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
  task automatic drive(input logic r, en, j, pu, rt, po, b,
                       input logic [11:0] ja, input logic [7:0] bo);
    @(negedge clk);
    rst = r; pcEn = en; jmp = j; push = pu; ret = rt; pop = po; branch = b;
    jmpAddr = ja; branchOff = bo;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pcEn = 1'b0; jmp = 1'b0; push = 1'b0; ret = 1'b0; pop = 1'b0;
    branch = 1'b0; jmpAddr = '0; branchOff = '0;

    //   rst en jmp psh ret pop br  jaddr  boff   pc    emp ful err
    add(1, 0, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd0,   1, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 0, 0, 0, 0, 0, 12'd0, 8'h00, 12'(i), 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 12'd10,  8'h00, 12'd10,  1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 12'd100, 8'h00, 12'd100, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd101, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 12'd0,   8'h00, 12'd11,  1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 12'd20,  8'h00, 12'd20,  1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 12'd0,   8'hFC, 12'd17,  1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 12'd0,   8'h05, 12'd23,  1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 12'd4095,8'h00, 12'd4095,1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd0,   1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1, 12'd55,  8'h03, 12'd0,   1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 12'd7,   8'h00, 12'd7,   1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 12'd0,   8'h00, 12'd8,   1, 0, 1);
    add(0, 1, 0, 1, 0, 1, 0, 12'd0,   8'h00, 12'd9,   1, 0, 1);
    add(0, 1, 1, 1, 0, 0, 0, 12'd200, 8'h00, 12'd200, 0, 0, 1);
    add(0, 1, 1, 1, 1, 1, 1, 12'd300, 8'h05, 12'd10,  1, 0, 1);
    add(0, 1, 1, 1, 0, 0, 0, 12'd50,  8'h00, 12'd50,  0, 0, 1);
    add(1, 1, 1, 1, 0, 0, 0, 12'd60,  8'h00, 12'd0,   1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 12'd0,   8'h00, 12'd1,   1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd0,   1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 12'd40,  8'h00, 12'd40,  0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 12'd0,   8'h00, 12'd1,   0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd2,   0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 12'd0,   8'h00, 12'd1,   0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 12'd0,   8'h00, 12'd1,   1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 12'd0,   8'h00, 12'd0,   1, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].jmp, vecs[k].push, vecs[k].ret,
            vecs[k].pop, vecs[k].br, vecs[k].jaddr, vecs[k].boff);
      chk($sformatf("v%0d_pc", k),    32'(pc),         32'(vecs[k].epc));
      chk($sformatf("v%0d_empty", k), 32'(stackEmpty), 32'(vecs[k].eempty));
      chk($sformatf("v%0d_full", k),  32'(stackFull),  32'(vecs[k].efull));
      chk($sformatf("v%0d_err", k),   32'(stackErr),   32'(vecs[k].eerr));
    end

    // Nine nested calls from pc=0: call k sits at pc 100*(k-1), targets 100*k.
    for (int k = 1; k <= 9; k++) begin
      logic [11:0] here;
      here = 12'(100 * (k - 1));
      drive(0, 1, 1, 1, 0, 0, 0, 12'(100 * k), 8'h00);
      if (k <= 8) exp_q.push_back(here + 12'd1);
      chk($sformatf("call%0d_pc", k),   32'(pc),        32'(100 * k));
      chk($sformatf("call%0d_full", k), 32'(stackFull), 32'(k >= 8));
      chk($sformatf("call%0d_err", k),  32'(stackErr),  32'(k == 9));
    end

    // Unwind: each return must land on the most recent surviving return address.
    for (int k = 1; k <= 8; k++) begin
      logic [11:0] exp_pc;
      exp_pc = exp_q.pop_back();
      drive(0, 1, 0, 0, 1, 1, 0, 12'd0, 8'h00);
      chk($sformatf("ret%0d_pc", k),    32'(pc),         32'(exp_pc));
      chk($sformatf("ret%0d_full", k),  32'(stackFull),  32'd0);
      chk($sformatf("ret%0d_empty", k), 32'(stackEmpty), 32'(k == 8));
    end
    chk("unwind_err_sticky", 32'(stackErr), 32'd1);

    // Ret with empty stack after unwind falls through and keeps the flag.
    drive(0, 1, 0, 0, 1, 1, 0, 12'd0, 8'h00);
    chk("post_unwind_ret_pc", 32'(pc), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
